data_memory_mmio: RTL
=====================

Name: data_memory_mmio

Overview:
Parametrised data memory for the pipelined MIPS core, with a memory-mapped peripheral page. Sits in the MEM stage. Adds over the previous data memory:
- byte, halfword and word accesses, with sign or zero extension on loads
- an interval timer with interrupt
- a free-running systick counter
- address/alignment error reporting

Parameters:
RAM_WORDS, 512, RAM depth in 32-bit words; must be a power of two.
LED_W, 8, width of the LED register.
DIGI_W, 12, width of the 7-segment data register.
MMIO_BASE, 32'h40000000, base address of the peripheral page.
RAM_RESET, 1, 1 = RAM cleared to zero by reset; 0 = RAM not reset (block-RAM inference).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
addr  in  32  byte address from ALU
wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
mem_read  in  1  load strobe
mem_write  in  1  store strobe
size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
load_unsigned  in  1  1 = zero-extend sub-word loads, 0 = sign-extend
rdata  out  32  load data, combinational
led  out  LED_W  LED register
digi  out  DIGI_W  7-segment data register
irq  out  1  timer interrupt, level
bus_err  out  1  registered one-cycle pulse on a bad access

Behaviour:
- Reset (async): led=0, digi=0, TH=0, TL=0, TCON=0, SYSTICK=0, bus_err=0, irq=0.
  - RAM is zeroed if RAM_RESET=1; otherwise it is untouched.
- Address decode:
  - RAM region is [0, RAM_WORDS*4). Word index is addr[log2(RAM_WORDS)+1:2].
  - MMIO offsets from MMIO_BASE (word access only):
    - 0x00 TH: reload value, R/W
    - 0x04 TL: counter, R/W
    - 0x08 TCON, R/W: [0] enable, [1] irq_en, [2] status (W1C)
    - 0x0C LED: R/W, low LED_W bits
    - 0x10 DIGI: R/W, low DIGI_W bits
    - 0x14 SYSTICK: read-only; writes ignored
  - Any other address is unmapped.
- Alignment:
  - half requires addr[0]=0; word requires addr[1:0]=0; size=11 is always misaligned.
  - MMIO accepts word accesses only; a sub-word MMIO access is an error.
- Stores:
  - Take effect on the posedge when mem_write=1 and the access is legal.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Only the enabled bytes are written; the other bytes of the word are preserved.
- Loads:
  - Combinational; rdata=0 when mem_read=0 or the access is illegal.
  - The sub-word is extracted from its lane, then sign- or zero-extended per load_unsigned.
  - Readable registers return their value zero-padded to 32 bits.
- bus_err:
  - Registered. Goes high the cycle after any strobe (mem_read or mem_write) to an unmapped, misaligned or size=11 address, for one cycle.
  - An illegal write changes no state.
  - mem_read and mem_write both high: the write is performed and the read data is the pre-write value.
- Timer (updates every cycle while TCON[0]=1):
  - TL != 32'hFFFFFFFF: TL <= TL+1.
  - TL == 32'hFFFFFFFF: TL <= TH and TCON[2] <= 1.
  - A CPU write to TL in the same cycle overrides the increment/reload.
  - A W1C of TCON[2] in the same cycle as an overflow: set wins, so the interrupt is not lost.
  - A CPU write to TCON updates bits [1:0]; bit[2] is only set by overflow and only cleared by W1C.
  - irq = TCON[2] & TCON[1].
  - Disabling the timer (TCON[0]=0) freezes TL; status is retained.
- SYSTICK: increments every cycle from reset, wraps modulo 2^32, is unaffected by any write.
- Reset asserted mid-operation: all state returns to reset values immediately; a store in that cycle is lost.

Decomposition:
- Shared package `mem_map_pkg`:
  - MMIO_BASE and the register offsets (TH, TL, TCON, LED, DIGI, SYSTICK)
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - TCON bit indices
- One sub-module, `mmio_timer`:
  - contains TH, TL, TCON and SYSTICK
  - inputs: write strobe, offset, wdata
  - outputs: read data, irq
- Byte-lane and extension logic stays in the top level.

Test Plan:
- Reset, then SW 0x12345678 @0x10, then LW @0x10 -> rdata=0x12345678; LW @0x14 -> 0.
- SB 0x000000AB @0x11 over word 0x12345678 -> LW @0x10 = 0x1234AB78.
  - LB @0x11 -> 0xFFFFFFAB; LBU @0x11 -> 0x000000AB.
  - SH 0xBEEF @0x12 -> LW = 0xBEEFAB78; LH @0x12 -> 0xFFFFBEEF.
- SW 0xA5 @0x4000000C -> led=0xA5 next cycle.
  - SW 0xFFF3 @0x40000010 -> digi=0xFF3.
  - LW @0x4000000C -> 0x000000A5.
- TH=0xFFFFFFFD, TL=0xFFFFFFFE, TCON=0x3:
  - overflow on 2nd enabled cycle -> TL=0xFFFFFFFD and irq=1.
  - SW 0x7 to TCON -> irq=0 next cycle.
  - Re-arm, then issue W1C on the exact overflow cycle -> irq stays 1.
- LW @0x13 (misaligned word) -> rdata=0, bus_err=1 next cycle only.
  - SW @0x800 (RAM_WORDS=512) -> no RAM change, bus_err pulse.
  - SB @0x4000000C -> bus_err pulse, led unchanged.
- Read SYSTICK twice, N cycles apart -> difference = N.
  - Assert reset mid-store -> store lost; all outputs and registers return to 0.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared address map, access-size encodings and timer control bits for the
// MEM-stage data memory and its peripheral page.
package mem_map_pkg;

  localparam logic [31:0] MMIO_BASE_ADDR = 32'h4000_0000;

  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LED     = 5'h0C;
  localparam logic [4:0] OFF_DIGI    = 5'h10;
  localparam logic [4:0] OFF_SYSTICK = 5'h14;

  // One past the last mapped peripheral byte offset
  localparam logic [31:0] MMIO_SPAN  = 32'h18;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_ST = 2;

endpackage

// File: rtl/mmio_timer.sv
// Interval timer (TH reload, TL counter, TCON control/status) and free-running
// systick; word-wide register file for the peripheral page.
module mmio_timer
  import mem_map_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  offset,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [31:0] th;
  logic [31:0] tl;
  logic [31:0] systick;
  logic [2:0]  tcon;
  logic        ovf;

  assign ovf = tcon[TCON_EN] && (tl == '1);
  assign irq = tcon[TCON_ST] & tcon[TCON_IE];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;

      if (we && offset == OFF_TL)
        tl <= wdata;
      else if (tcon[TCON_EN])
        tl <= ovf ? th : tl + 32'd1;

      if (we && offset == OFF_TH)
        th <= wdata;

      if (we && offset == OFF_TCON) begin
        tcon[TCON_EN] <= wdata[TCON_EN];
        tcon[TCON_IE] <= wdata[TCON_IE];
      end

      // Overflow set takes priority over a same-cycle W1C so no interrupt is dropped
      if (ovf)
        tcon[TCON_ST] <= 1'b1;
      else if (we && offset == OFF_TCON && wdata[TCON_ST])
        tcon[TCON_ST] <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_TH:      rdata = th;
      OFF_TL:      rdata = tl;
      OFF_TCON:    rdata = {29'd0, tcon};
      OFF_SYSTICK: rdata = systick;
      default:     rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_mmio.sv
// MEM-stage data memory: byte/half/word RAM with sign/zero-extended loads,
// a memory-mapped peripheral page (timer, systick, LED, 7-seg) and bus errors.
module data_memory_mmio
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 512,
  parameter int unsigned LED_W     = 8,
  parameter int unsigned DIGI_W    = 12,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_ADDR,
  parameter bit          RAM_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  output logic [31:0]       rdata,
  output logic [LED_W-1:0]  led,
  output logic [DIGI_W-1:0] digi,
  output logic              irq,
  output logic              bus_err
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  size_e         sz;
  logic [31:0]   off;
  logic          ram_hit, mmio_hit, aligned, legal;
  logic          ram_we, mmio_we;
  logic [AW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   word_rd, mmio_rd, tmr_rd;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   ram [RAM_WORDS];

  assign sz       = size_e'(size);
  assign off      = addr - MMIO_BASE;
  assign ram_hit  = (addr[31:AW+2] == '0);
  assign mmio_hit = (off < MMIO_SPAN);
  assign widx     = addr[AW+1:2];

  always_comb begin
    case (sz)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = ~addr[0];
      SZ_WORD: aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign legal   = aligned & (ram_hit | (mmio_hit & (sz == SZ_WORD)));
  assign ram_we  = mem_write & legal & ram_hit;
  assign mmio_we = mem_write & legal & ~ram_hit;

  always_comb begin
    case (sz)
      SZ_BYTE: begin
        be    = 4'b0001 << addr[1:0];
        wlane = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata;
      end
    endcase
  end

  if (RAM_RESET) begin : g_ram_rst
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int unsigned i = 0; i < RAM_WORDS; i++)
          ram[i] <= '0;
      end else if (ram_we) begin
        for (int unsigned b = 0; b < 4; b++)
          if (be[b]) ram[widx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end else begin : g_ram_nrst
    // No reset on the array so it maps to block RAM; reset still blocks the store
    always_ff @(posedge clk) begin
      if (ram_we && !reset) begin
        for (int unsigned b = 0; b < 4; b++)
          if (be[b]) ram[widx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  mmio_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .we     (mmio_we),
    .offset (off[4:0]),
    .wdata  (wdata),
    .rdata  (tmr_rd),
    .irq    (irq)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led     <= '0;
      digi    <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= (mem_read | mem_write) & ~legal;
      if (mmio_we && off[4:0] == OFF_LED)
        led <= wdata[LED_W-1:0];
      if (mmio_we && off[4:0] == OFF_DIGI)
        digi <= wdata[DIGI_W-1:0];
    end
  end

  always_comb begin
    case (off[4:0])
      OFF_LED:  mmio_rd = 32'(led);
      OFF_DIGI: mmio_rd = 32'(digi);
      default:  mmio_rd = tmr_rd;
    endcase
  end

  assign word_rd = ram_hit ? ram[widx] : mmio_rd;
  assign byte_v  = word_rd[{addr[1:0], 3'b000} +: 8];
  assign half_v  = word_rd[{addr[1], 4'b0000} +: 16];

  always_comb begin
    rdata = '0;
    if (mem_read && legal) begin
      case (sz)
        SZ_BYTE: rdata = load_unsigned ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
        SZ_HALF: rdata = load_unsigned ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
        default: rdata = word_rd;
      endcase
    end
  end

endmodule
